bram_cmd_sequencer: RTL and testbench

Command sequencer directly upstream of the BRAM stream interface (`stream_interface_s`). It accepts one host transfer command, checks it against the 25088-entry BRAM address space, and splits it into bursts of at most MAX_BURST beats. Each burst is issued as one 64-bit instruction word on the interface's instruction port. Before issuing the next burst, it counts data-stream handshakes until the current burst completes.

---
 rtl/bram_cmd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_bram_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_cmd_sequencer.sv
// Command sequencer feeding the BRAM stream interface: validates one host transfer
// command, splits it into bursts of at most MAX_BURST beats and tracks completion.
module bram_cmd_sequencer #(
    parameter logic [1:0]  RMODE     = 2'b01,
    parameter logic [1:0]  WMODE     = 2'b00,
    parameter logic [14:0] MAX_BURST = 15'd1024,
    parameter logic [15:0] DEPTH     = 16'd25088
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] s_cmd_tdata,
    input  logic        s_cmd_tvalid,
    output logic        s_cmd_tready,
    output logic [63:0] m_instruct_tdata,
    output logic        m_instruct_tvalid,
    input  logic        m_instruct_tready,
    input  logic        mon_tvalid,
    input  logic        mon_tready,
    input  logic        mon_tlast,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    function automatic logic [14:0] burst_len(input logic [14:0] remaining);
        burst_len = (remaining > MAX_BURST) ? MAX_BURST : remaining;
    endfunction

    function automatic logic [63:0] instr_word(input logic [14:0] len, input logic [14:0] addr,
                                               input logic [1:0] mode, input logic ws);
        instr_word = {30'd0, ws, 1'b0, mode, addr, len};
    endfunction

    logic [2:0]  state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [14:0] rem_q, rem_d;
    logic [14:0] blen_q, blen_d;
    logic [14:0] cnt_q, cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [63:0] instr_q, instr_d;
    logic        ivalid_q, ivalid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [14:0] cmd_total_s;
    logic [14:0] cmd_start_s;
    logic [1:0]  cmd_mode_s;
    logic        cmd_ws_s;
    logic [15:0] cmd_end_s;
    logic        cmd_bad_s;
    logic        accept_s;
    logic        beat_s;
    logic [14:0] cnt_inc_s;
    logic        burst_end_s;
    logic        early_s;
    logic        early_err_s;
    logic [14:0] rem_after_s;
    logic [14:0] addr_after_s;
    logic        unused_s;

    assign cmd_total_s = s_cmd_tdata[14:0];
    assign cmd_start_s = s_cmd_tdata[29:15];
    assign cmd_mode_s  = s_cmd_tdata[31:30];
    assign cmd_ws_s    = s_cmd_tdata[32];
    assign unused_s    = ^s_cmd_tdata[47:33];

    // End address is formed one bit wider so the bound check cannot wrap.
    assign cmd_end_s = {1'b0, cmd_start_s} + {1'b0, cmd_total_s};
    assign cmd_bad_s = ((cmd_mode_s != RMODE) && (cmd_mode_s != WMODE)) || (cmd_end_s > DEPTH);
    assign accept_s  = (state_q == ST_IDLE) && cmd_ready_q && s_cmd_tvalid;

    assign beat_s       = mon_tvalid && mon_tready;
    assign cnt_inc_s    = cnt_q + 15'd1;
    assign burst_end_s  = beat_s && ((cnt_inc_s == blen_q) || mon_tlast);
    assign early_s      = beat_s && mon_tlast && (cnt_inc_s < blen_q);
    assign rem_after_s  = rem_q - blen_q;
    assign addr_after_s = addr_q + blen_q;

    // Next-state logic for the sequencing FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        blen_d      = blen_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        instr_d     = instr_q;
        ivalid_d    = ivalid_q;
        early_err_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    mode_d = cmd_mode_s;
                    addr_d = cmd_start_s;
                    rem_d  = cmd_total_s;
                    cnt_d  = 15'd0;
                    if (cmd_bad_s) begin
                        state_d = ST_ERR;
                    end else if (cmd_total_s == 15'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_ISSUE;
                        blen_d   = burst_len(cmd_total_s);
                        instr_d  = instr_word(burst_len(cmd_total_s), cmd_start_s, cmd_mode_s, cmd_ws_s);
                        ivalid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (m_instruct_tready) begin
                    ivalid_d = 1'b0;
                    state_d  = ST_WAIT;
                end else begin
                    ivalid_d = 1'b1;
                end
            end
            ST_WAIT: begin
                // An early tlast still retires the full burst so addressing stays deterministic.
                if (burst_end_s) begin
                    early_err_s = early_s;
                    cnt_d       = 15'd0;
                    rem_d       = rem_after_s;
                    addr_d      = addr_after_s;
                    if (rem_after_s != 15'd0) begin
                        state_d  = ST_ISSUE;
                        blen_d   = burst_len(rem_after_s);
                        instr_d  = instr_word(burst_len(rem_after_s), addr_after_s, mode_q, 1'b0);
                        ivalid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (beat_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                ivalid_d = 1'b0;
            end
        endcase
    end

    // Status outputs are registered from the upcoming state so they align with it.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR) || early_err_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 15'd0;
            rem_q       <= 15'd0;
            blen_q      <= 15'd0;
            cnt_q       <= 15'd0;
            mode_q      <= 2'd0;
            instr_q     <= 64'd0;
            ivalid_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            blen_q      <= blen_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            instr_q     <= instr_d;
            ivalid_q    <= ivalid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign s_cmd_tready      = cmd_ready_q;
    assign m_instruct_tdata  = instr_q;
    assign m_instruct_tvalid = ivalid_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

endmodule

// File: tb/tb_bram_cmd_sequencer.sv
// Scoreboard bench for bram_cmd_sequencer: a burst-list model predicts instructions and
// done/err pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_bram_cmd_sequencer;
    localparam int MAXB  = 1024;
    localparam int DEPTH = 25088;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] s_cmd_tdata;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic [63:0] m_instruct_tdata;
    logic        m_instruct_tvalid;
    logic        m_instruct_tready;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic        busy;
    logic        done;
    logic        err;

    int errors  = 0;
    int checks  = 0;
    int cur_tag = 0;
    logic [63:0] exp_instr_q[$];
    int exp_done_q[$];
    int exp_err_q[$];
    int plan_q[$];
    bit pending_err = 1'b0;

    bram_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
        .m_instruct_tdata(m_instruct_tdata), .m_instruct_tvalid(m_instruct_tvalid),
        .m_instruct_tready(m_instruct_tready),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: nothing expected, got %h (t=%0t)", name, act, $time);
    endtask

    function automatic logic [63:0] instr_word(input int len, input int addr, input int mode, input int ws);
        longint w;
        w = longint'(len) + longint'(addr) * 64'd32768 + longint'(mode) * 64'd1073741824
          + longint'(ws) * 64'd8589934592;
        return w[63:0];
    endfunction

    // Reference: chop the command into bursts and predict every observable event.
    task automatic model_cmd(input int mode, input int start, input int total, input int ws,
                             input int early_b, input int early_k, output bit bad);
        int rem;
        int addr;
        int len;
        int b;
        cur_tag++;
        plan_q.delete();
        bad = ((mode != 0) && (mode != 1)) || (start + total > DEPTH);
        if (bad) begin
            exp_err_q.push_back(cur_tag);
        end else if (total == 0) begin
            exp_done_q.push_back(cur_tag);
        end else begin
            rem = total; addr = start; b = 0;
            while (rem > 0) begin
                len = (rem < MAXB) ? rem : MAXB;
                exp_instr_q.push_back(instr_word(len, addr, mode, (b == 0) ? ws : 0));
                plan_q.push_back(len);
                if (b == early_b && early_k < len) exp_err_q.push_back(cur_tag);
                rem -= len; addr += len; b++;
            end
            exp_done_q.push_back(cur_tag);
        end
    endtask

    task automatic submit(input logic [47:0] w);
        bit ok = 1'b0;
        s_cmd_tdata = w;
        s_cmd_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_cmd_tready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_cmd_tvalid = 1'b0;
        s_cmd_tdata = {16'($urandom), 32'($urandom)};
        check("cmd_accept", ok, 1);
    endtask

    task automatic wait_instr(input int stall);
        bit ok = 1'b0;
        int hs_i = -1;
        for (int i = 0; i < 200; i++) begin
            if (i < stall) m_instruct_tready = 1'b0;
            else if (stall > 0 && i == stall) m_instruct_tready = 1'b1;
            else m_instruct_tready = ($urandom_range(0, 3) != 0);
            mon_tvalid = 1'($urandom_range(0, 1));
            mon_tready = 1'($urandom_range(0, 1));
            mon_tlast  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (i == 0) begin
                check("instr_latency", m_instruct_tvalid, 1);
                check("busy_active", busy, 1);
                check("early_err", err, pending_err);
            end
            if (m_instruct_tvalid && m_instruct_tready) begin ok = 1'b1; hs_i = i; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        m_instruct_tready = 1'b0;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        check("instr_handshake", ok, 1);
        if (stall > 0) check("stall_accept_cycle", hs_i, stall);
    endtask

    task automatic send_beats(input int len, input int tk);
        int n = 0;
        int guard = 0;
        int target;
        bit v;
        bit r;
        target = (tk > 0) ? tk : len;
        while (n < target && guard < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            mon_tvalid = v;
            mon_tready = r;
            mon_tlast  = (v && r) ? (n + 1 == tk) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (v && r) n++;
            @(posedge clk); #1;
            guard++;
        end
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        check("beats_sent", n, target);
    endtask

    task automatic finish_cmd();
        int wait_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_cmd_tready) begin wait_cyc = i; break; end
            @(posedge clk); #1;
        end
        check("ready_latency", wait_cyc, 0);
        check("busy_idle", busy, 0);
        check("instr_q_empty", exp_instr_q.size(), 0);
        check("done_q_empty", exp_done_q.size(), 0);
        check("err_q_empty", exp_err_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input int mode, input int start, input int total, input int ws,
                           input int stall, input int early_b, input int early_k);
        logic [47:0] w;
        bit bad;
        int nb;
        int tk;
        model_cmd(mode, start, total, ws, early_b, early_k, bad);
        w = {15'($urandom_range(0, 32767)), 1'(ws), 2'(mode), 15'(start), 15'(total)};
        submit(w);
        nb = plan_q.size();
        if (nb == 0) begin
            @(negedge clk);
            check("reject_err", err, bad);
            check("zero_done", done, !bad);
            check("no_instr", m_instruct_tvalid, 0);
            check("busy_short", busy, 1);
            @(posedge clk); #1;
        end else begin
            pending_err = 1'b0;
            for (int b = 0; b < nb; b++) begin
                wait_instr((b == 0) ? stall : 0);
                tk = (b == early_b && early_k <= plan_q[b]) ? early_k : 0;
                send_beats(plan_q[b], tk);
                pending_err = (tk > 0 && tk < plan_q[b]);
            end
            @(negedge clk);
            check("done_latency", done, 1);
            check("err_with_done", err, pending_err);
            pending_err = 1'b0;
            @(posedge clk); #1;
        end
        finish_cmd();
    endtask

    // Monitor: compares handshaken instructions, done/err pulses and hold-stability.
    initial begin : monitor
        bit prev_stall;
        logic [63:0] prev_data;
        int tag;
        prev_stall = 1'b0;
        prev_data = 64'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_instruct_tvalid, 1);
                    check("hold_data", m_instruct_tdata, prev_data);
                end
                if (m_instruct_tvalid && m_instruct_tready) begin
                    if (exp_instr_q.size() == 0) note_fail("unexpected_instr", m_instruct_tdata);
                    else check("instr_word", m_instruct_tdata, exp_instr_q.pop_front());
                end
                if (done) begin
                    if (exp_done_q.size() == 0) note_fail("unexpected_done", 1);
                    else begin tag = exp_done_q.pop_front(); check("done_tag", tag, cur_tag); end
                end
                if (err) begin
                    if (exp_err_q.size() == 0) note_fail("unexpected_err", 1);
                    else begin tag = exp_err_q.pop_front(); check("err_tag", tag, cur_tag); end
                end
                prev_stall = m_instruct_tvalid && !m_instruct_tready;
                prev_data  = m_instruct_tdata;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: time limit reached with errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        s_cmd_tdata = 48'd0; s_cmd_tvalid = 1'b0; m_instruct_tready = 1'b0;
        mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", s_cmd_tready, 0);
        check("rst_ivalid", m_instruct_tvalid, 0);
        check("rst_idata", m_instruct_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_reset", s_cmd_tready, 1);
        @(posedge clk); #1;

        run_cmd(1, 100, 2500, 1, 0, -1, 0);
        run_cmd(0, 12540, 8, 0, 5, -1, 0);
        run_cmd(1, 25000, 89, 1, 0, -1, 0);
        run_cmd(0, 25000, 88, 1, 0, -1, 0);
        run_cmd(1, 300, 0, 1, 0, -1, 0);
        run_cmd(2, 0, 10, 0, 0, -1, 0);
        run_cmd(3, 40, 5, 1, 0, -1, 0);
        run_cmd(1, 0, 1040, 1, 0, 0, 10);
        run_cmd(0, 5000, 16, 1, 0, 0, 10);
        run_cmd(1, 7, 1024, 1, 1, -1, 0);
        run_cmd(0, 24063, 1025, 1, 2, -1, 0);

        // Reset in the middle of a burst discards the command.
        begin
            bit bad;
            model_cmd(1, 500, 40, 1, -1, 0, bad);
            submit({15'd0, 1'b1, 2'b01, 15'd500, 15'd40});
            wait_instr(0);
            send_beats(10, 0);
            rst_n = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            check("midrst_ready", s_cmd_tready, 0);
            check("midrst_ivalid", m_instruct_tvalid, 0);
            check("midrst_idata", m_instruct_tdata, 0);
            check("midrst_busy", busy, 0);
            check("midrst_done", done, 0);
            check("midrst_err", err, 0);
            exp_instr_q.delete(); exp_done_q.delete(); exp_err_q.delete();
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            run_cmd(0, 9, 20, 1, 0, -1, 0);
        end

        for (int t = 0; t < 10; t++) begin
            int mode;
            int start;
            int total;
            mode = $urandom_range(0, 9);
            mode = (mode == 8) ? 2 : (mode == 9) ? 3 : (mode % 2);
            start = $urandom_range(0, 25087);
            total = $urandom_range(0, 1500);
            if (t % 3 == 0) begin
                start = $urandom_range(23600, 25088);
                total = DEPTH - start + $urandom_range(0, 1);
            end
            run_cmd(mode, start, total, $urandom_range(0, 1), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(1, 1100));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
